ram_access_arbiter: RTL and testbench

//  Shares the single-port main RAM between the instruction fetch port and the

---
 rtl/ram_access_arbiter.sv | 136 +++++++++++++
 tb/tb_ram_access_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_arbiter.sv
// Shares the single-port main RAM between the instruction fetch port and the data port.
// One access is in flight at a time. Data wins by default, and a starvation counter forces fetch progress.
module ram_access_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_WAIT     = 15,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ramready,
  input  logic              ramerr,
  output logic              err
);
  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WAIT - 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(MAX_WAIT);
  localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, IACC, DACC, IDONE, DDONE, ERROR} state_t;

  state_t            state;
  logic [WCNT_W-1:0] waitcnt;
  logic [SCNT_W-1:0] starve;
  logic              dreq;
  logic              force_fetch;
  logic              timeout;

  function automatic logic [WCNT_W-1:0] sat_inc_wait(input logic [WCNT_W-1:0] v);
    return (v == WCNT_MAX) ? v : v + WCNT_W'(1);
  endfunction

  function automatic logic [SCNT_W-1:0] sat_inc_starve(input logic [SCNT_W-1:0] v);
    return (v == SCNT_MAX) ? v : v + SCNT_W'(1);
  endfunction

  assign dreq        = dREN | dWEN;
  assign force_fetch = iREN && (starve == SCNT_MAX);
  // waitcnt holds the count before this cycle, so LAST marks the MAX_WAIT-th strobe cycle
  assign timeout     = (waitcnt == WCNT_LAST);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      iwait    <= 1'b1;
      dwait    <= 1'b1;
      iload    <= '0;
      dload    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      err      <= 1'b0;
      waitcnt  <= '0;
      starve   <= '0;
    end else begin
      case (state)
        IDLE: begin
          waitcnt <= '0;
          if (dreq && !force_fetch) begin
            state    <= DACC;
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramWEN   <= dWEN;
            ramREN   <= !dWEN;
            starve   <= iREN ? sat_inc_starve(starve) : '0;
          end else if (iREN) begin
            state   <= IACC;
            ramaddr <= iaddr;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
            starve  <= '0;
          end
        end
        IACC, DACC: begin
          if (ramerr || (!ramready && timeout)) begin
            state  <= ERROR;
            err    <= 1'b1;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
          end else if (ramready) begin
            waitcnt <= '0;
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            if (state == IACC) begin
              iload <= ramload;
              iwait <= 1'b0;
              state <= IDONE;
            end else begin
              // ramWEN still carries the latched op of this data access
              if (!ramWEN) dload <= ramload;
              dwait <= 1'b0;
              state <= DDONE;
            end
          end else begin
            waitcnt <= sat_inc_wait(waitcnt);
          end
        end
        IDONE, DDONE: begin
          iwait <= 1'b1;
          dwait <= 1'b1;
          state <= IDLE;
        end
        ERROR: begin
          err    <= 1'b1;
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
          iwait  <= 1'b1;
          dwait  <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter.
// It uses a behavioural RAM responder, a table of directed transactions, corner sequences and a randomized transaction model.
module tb_ram_access_arbiter;
  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic        ramready = 1'b0;
  logic        ramerr = 1'b0;
  logic        err;

  ram_access_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .ramerr(ramerr), .err(err)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  // RAM environment: ready after ram_lat strobe cycles (0 = never), optional fault
  int ram_lat = 1;
  bit ram_err_en = 1'b0;
  int ram_err_at = 0;
  int scnt = 0;
  logic [31:0] ram_mem [bit [31:0]];

  // Reference model state
  logic [31:0] ref_mem [bit [31:0]];
  int          starve_m = 0;
  logic [31:0] exp_iload = '0;
  logic [31:0] exp_dload = '0;

  typedef struct {
    bit          i;
    logic [31:0] ia;
    bit          r;
    bit          w;
    logic [31:0] da;
    logic [31:0] ds;
    int          lat;
    bit          exp_d;
    bit          exp_wen;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic vec_t mk(input bit i, input logic [31:0] ia, input bit r, input bit w,
                              input logic [31:0] da, input logic [31:0] ds, input int lat,
                              input bit exp_d, input bit exp_wen);
    vec_t v;
    v.i = i; v.ia = ia; v.r = r; v.w = w; v.da = da; v.ds = ds; v.lat = lat;
    v.exp_d = exp_d; v.exp_wen = exp_wen;
    return v;
  endfunction

  always @(negedge CLK) begin
    if (ramREN || ramWEN) begin
      scnt = scnt + 1;
      ramerr = ram_err_en && (scnt == ram_err_at);
      if (ram_lat != 0 && scnt == ram_lat) begin
        ramready = 1'b1;
        if (ramWEN) ram_mem[ramaddr] = ramstore;
        ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : dflt(ramaddr);
      end else begin
        ramready = 1'b0;
        ramload = $urandom;
      end
    end else begin
      scnt = 0;
      ramready = 1'b0;
      ramerr = 1'b0;
      ramload = $urandom;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".waits"}, 64'({iwait, dwait}), 64'(2'b11));
    check({tag, ".iload"}, 64'(iload), 64'(0));
    check({tag, ".dload"}, 64'(dload), 64'(0));
    check({tag, ".strobes"}, 64'({ramREN, ramWEN}), 64'(0));
    check({tag, ".ramaddr"}, 64'(ramaddr), 64'(0));
    check({tag, ".ramstore"}, 64'(ramstore), 64'(0));
    check({tag, ".err"}, 64'(err), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    @(negedge CLK);
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    #2 nRST = 1'b0;
    #1 check_reset_vals(tag);
    @(negedge CLK);
    nRST = 1'b1;
    starve_m = 0; exp_iload = '0; exp_dload = '0; ram_err_en = 1'b0;
  endtask

  task automatic txn(input string tag, input bit i, input logic [31:0] ia, input bit r, input bit w,
                     input logic [31:0] da, input logic [31:0] ds, input int lat,
                     input bit exp_d, input bit exp_wen);
    logic [31:0] ea;
    int cyc;
    int sc;
    ea = exp_d ? da : ia;
    ram_lat = lat;
    @(posedge CLK); #1;
    iREN = i; iaddr = ia; dREN = r; dWEN = w; daddr = da; dstore = ds;
    @(posedge CLK); #1;
    // inputs wander and requests drop once the access is latched
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = $urandom; daddr = $urandom; dstore = $urandom;
    if (exp_d) starve_m = i ? ((starve_m < 4) ? starve_m + 1 : 4) : 0;
    else starve_m = 0;
    @(negedge CLK);
    check({tag, ".ramREN"}, 64'(ramREN), 64'(!exp_wen));
    check({tag, ".ramWEN"}, 64'(ramWEN), 64'(exp_wen));
    check({tag, ".ramaddr"}, 64'(ramaddr), 64'(ea));
    if (exp_wen) check({tag, ".ramstore"}, 64'(ramstore), 64'(ds));
    cyc = 0;
    sc = 0;
    while (iwait && dwait && cyc < 40) begin
      if (ramREN || ramWEN) sc++;
      cyc++;
      @(negedge CLK);
    end
    check({tag, ".latency"}, 64'(cyc), 64'(lat));
    check({tag, ".strobe_cycles"}, 64'(sc), 64'(lat));
    if (exp_wen) ref_mem[da] = ds;
    else if (exp_d) exp_dload = rd(da);
    else exp_iload = rd(ia);
    check({tag, ".iwait"}, 64'(iwait), 64'(exp_d));
    check({tag, ".dwait"}, 64'(dwait), 64'(!exp_d));
    check({tag, ".iload"}, 64'(iload), 64'(exp_iload));
    check({tag, ".dload"}, 64'(dload), 64'(exp_dload));
    check({tag, ".done_strobes"}, 64'({ramREN, ramWEN}), 64'(0));
    @(negedge CLK);
    check({tag, ".release"}, 64'({iwait, dwait}), 64'(2'b11));
  endtask

  task automatic idle_check(input string tag);
    @(posedge CLK); #1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check({tag, ".quiet"}, 64'({ramREN, ramWEN, iwait, dwait}), 64'(4'b0011));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int sc;
    int got;
    int drops;
    bit expd [10];

    tbl[0] = mk(1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,        2,  1'b0, 1'b0);
    tbl[1] = mk(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'hDEADBEEF, 1,  1'b1, 1'b1);
    tbl[2] = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h80, 32'h0,        1,  1'b1, 1'b0);
    tbl[3] = mk(1'b0, 32'h0,  1'b1, 1'b1, 32'h84, 32'h12345678, 3,  1'b1, 1'b1);
    tbl[4] = mk(1'b1, 32'h84, 1'b0, 1'b0, 32'h0,  32'h0,        1,  1'b0, 1'b0);
    tbl[5] = mk(1'b1, 32'h40, 1'b1, 1'b0, 32'h88, 32'h0,        4,  1'b1, 1'b0);
    tbl[6] = mk(1'b1, 32'h08, 1'b0, 1'b0, 32'h0,  32'h0,        15, 1'b0, 1'b0);
    tbl[7] = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h84, 32'h0,        14, 1'b1, 1'b0);

    do_reset("rst0");
    for (int k = 0; k < 8; k++)
      txn($sformatf("tbl%0d", k), tbl[k].i, tbl[k].ia, tbl[k].r, tbl[k].w,
          tbl[k].da, tbl[k].ds, tbl[k].lat, tbl[k].exp_d, tbl[k].exp_wen);

    // simultaneous fetch and data write: data first, then fetch after an idle gap
    do_reset("rst2");
    ram_lat = 1;
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h100; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEADBEEF;
    @(posedge CLK); #1;
    dWEN = 1'b0; daddr = 32'h0; dstore = 32'h0;
    @(negedge CLK);
    check("t2.ramWEN", 64'(ramWEN), 64'(1));
    check("t2.ramREN", 64'(ramREN), 64'(0));
    check("t2.ramaddr", 64'(ramaddr), 64'(32'h80));
    check("t2.ramstore", 64'(ramstore), 64'(32'hDEADBEEF));
    ref_mem[32'h80] = 32'hDEADBEEF;
    @(negedge CLK);
    check("t2.ddone", 64'({iwait, dwait}), 64'(2'b10));
    @(negedge CLK);
    check("t2.gap", 64'({ramREN, ramWEN, iwait, dwait}), 64'(4'b0011));
    @(negedge CLK);
    check("t2.fetch_ren", 64'({ramREN, ramWEN}), 64'(2'b10));
    check("t2.fetch_addr", 64'(ramaddr), 64'(32'h100));
    iREN = 1'b0;
    @(negedge CLK);
    check("t2.idone", 64'({iwait, dwait}), 64'(2'b01));
    check("t2.iload", 64'(iload), 64'(rd(32'h100)));

    // starvation: both ports held, four data grants then one fetch, repeating
    do_reset("rst3");
    ram_lat = 1;
    expd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h10; dREN = 1'b1; daddr = 32'hC0;
    got = 0;
    cyc = 0;
    while (got < 10 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      if (!dwait || !iwait) begin
        check($sformatf("t3.grant%0d", got), 64'(!dwait), 64'(expd[got]));
        got++;
      end
    end
    check("t3.grant_count", 64'(got), 64'(10));
    iREN = 1'b0; dREN = 1'b0;

    // RAM never ready: timeout after MAX_WAIT strobe cycles, ERROR absorbs
    do_reset("rst4");
    ram_lat = 0;
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h200;
    @(posedge CLK); #1;
    iREN = 1'b0;
    @(negedge CLK);
    sc = 0;
    cyc = 0;
    while ((ramREN || ramWEN) && cyc < 40) begin
      sc++;
      cyc++;
      @(negedge CLK);
    end
    check("t4.strobe_cycles", 64'(sc), 64'(15));
    check("t4.err", 64'(err), 64'(1));
    iREN = 1'b1; dREN = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("t4.absorb", 64'({err, iwait, dwait, ramREN, ramWEN}), 64'(5'b11100));
    end

    // ramerr together with ramready on a data read
    do_reset("rst5");
    ram_lat = 2; ram_err_en = 1'b1; ram_err_at = 2;
    @(posedge CLK); #1;
    dREN = 1'b1; daddr = 32'h300;
    @(posedge CLK); #1;
    dREN = 1'b0;
    drops = 0;
    repeat (10) begin
      @(negedge CLK);
      if (!dwait) drops++;
    end
    check("t5.dwait_drops", 64'(drops), 64'(0));
    check("t5.state", 64'({err, iwait, dwait, ramREN, ramWEN}), 64'(5'b11100));
    check("t5.dload", 64'(dload), 64'(0));

    // asynchronous reset in the middle of a fetch, then a fresh fetch
    do_reset("rst6");
    ram_lat = 5;
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h400;
    @(posedge CLK); #1;
    iREN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("t6.in_access", 64'(ramREN), 64'(1));
    #2 nRST = 1'b0;
    #1 check_reset_vals("t6.async");
    @(negedge CLK);
    nRST = 1'b1;
    starve_m = 0; exp_iload = '0; exp_dload = '0;
    txn("t6.fresh", 1'b1, 32'h404, 1'b0, 1'b0, 32'h0, 32'h0, 2, 1'b0, 1'b0);

    // randomized transactions against the transaction-level model
    do_reset("rst_rand");
    for (int k = 0; k < 60; k++) begin
      bit ri;
      bit rr;
      bit rw;
      bit dq;
      bit ed;
      int kind;
      int rl;
      logic [31:0] ra;
      logic [31:0] rda;
      logic [31:0] rds;
      ri = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 2);
      rw = (kind == 2);
      rr = (kind == 1) || ((kind == 2) && ($urandom_range(0, 1) == 1));
      ra = $urandom_range(0, 15) << 2;
      rda = $urandom_range(0, 15) << 2;
      rds = $urandom;
      rl = $urandom_range(1, 6);
      dq = rr | rw;
      if (!dq && !ri) begin
        idle_check($sformatf("rnd%0d", k));
      end else begin
        ed = dq && !(starve_m == 4 && ri);
        txn($sformatf("rnd%0d", k), ri, ra, rr, rw, rda, rds, rl, ed, ed && rw);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
